// File: rtl/btb_setassoc.sv
// Set-associative branch target buffer with registered lookup, per-entry
// saturating direction counters and per-set round-robin replacement.
module btb_setassoc #(
  parameter int NSETS    = 16,
  parameter int NWAYS    = 2,
  parameter int CTR_BITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic [31:0]              fetch_pc,
  output logic                     hit,
  output logic                     taken,
  output logic [31:0]              target,
  output logic [$clog2(NWAYS)-1:0] hit_way,
  input  logic                     upd_en,
  input  logic [31:0]              upd_pc,
  input  logic [31:0]              upd_target,
  input  logic                     upd_taken,
  input  logic                     upd_hit,
  input  logic [$clog2(NWAYS)-1:0] upd_way
);

  localparam int IDX  = $clog2(NSETS);
  localparam int WB   = $clog2(NWAYS);
  localparam int TAGW = 30 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};

  logic [NWAYS-1:0]    valid   [NSETS];
  logic [WB-1:0]       vptr    [NSETS];
  logic [TAGW-1:0]     tag_mem [NSETS][NWAYS];
  logic [29:0]         tgt_mem [NSETS][NWAYS];
  logic [CTR_BITS-1:0] ctr_mem [NSETS][NWAYS];

  logic [IDX-1:0]      f_idx, u_idx;
  logic [TAGW-1:0]     f_tag, u_tag;
  logic                l_hit;
  logic [WB-1:0]       l_way;
  logic                u_match, inv_found, do_train, do_alloc;
  logic [WB-1:0]       inv_way, alloc_way;
  logic [CTR_BITS-1:0] cur_ctr, next_ctr;
  logic                unused_low_bits;

  assign f_idx = fetch_pc[IDX+1:2];
  assign f_tag = fetch_pc[31:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[31:IDX+2];
  assign unused_low_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup match; scanning downward leaves the lowest matching way selected.
  always_comb begin
    l_hit = 1'b0;
    l_way = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (valid[f_idx][w] && (tag_mem[f_idx][w] == f_tag)) begin
        l_hit = 1'b1;
        l_way = WB'(w);
      end else begin
        l_hit = l_hit;
      end
    end
  end

  // Update classification: a stale prediction-time hit is handled as a miss.
  always_comb begin
    u_match   = upd_hit && valid[u_idx][upd_way] && (tag_mem[u_idx][upd_way] == u_tag);
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!valid[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end else begin
        inv_found = inv_found;
      end
    end
    alloc_way = inv_found ? inv_way : vptr[u_idx];
    do_train  = upd_en && u_match;
    do_alloc  = upd_en && !u_match && upd_taken;
    cur_ctr   = ctr_mem[u_idx][upd_way];
    if (upd_taken) begin
      next_ctr = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_BITS'(1);
    end else begin
      next_ctr = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_BITS'(1);
    end
  end

  // Reset-tracked state: valid bits, victim pointers and lookup outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSETS; s++) begin
        valid[s] <= '0;
        vptr[s]  <= '0;
      end
      hit     <= 1'b0;
      taken   <= 1'b0;
      target  <= 32'h0000_0000;
      hit_way <= '0;
    end else begin
      if (fetch_en) begin
        hit     <= l_hit;
        taken   <= l_hit & ctr_mem[f_idx][l_way][CTR_BITS-1];
        target  <= l_hit ? {tgt_mem[f_idx][l_way], 2'b00} : 32'h0000_0000;
        hit_way <= l_way;
      end
      if (do_alloc) begin
        valid[u_idx][alloc_way] <= 1'b1;
        if (!inv_found) begin
          vptr[u_idx] <= vptr[u_idx] + WB'(1);
        end
      end
    end
  end

  // Entry payload arrays; no reset needed since valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!reset && do_train) begin
      ctr_mem[u_idx][upd_way] <= next_ctr;
      if (upd_taken) begin
        tgt_mem[u_idx][upd_way] <= upd_target[31:2];
      end
    end else if (!reset && do_alloc) begin
      tag_mem[u_idx][alloc_way] <= u_tag;
      tgt_mem[u_idx][alloc_way] <= upd_target[31:2];
      ctr_mem[u_idx][alloc_way] <= CTR_INIT;
    end
  end

endmodule

// File: tb/tb_btb_setassoc.sv
// Bench for btb_setassoc: directed scenarios then randomized traffic, all
// checked against an array-based behavioural model of the buffer.
module tb_btb_setassoc;
  localparam int NSETS = 16, NWAYS = 2, CTR_BITS = 2;
  localparam int IDX = $clog2(NSETS), WB = $clog2(NWAYS);
  localparam int CMAX = (1 << CTR_BITS) - 1;
  localparam int CINIT = 1 << (CTR_BITS - 1);

  logic clk = 1'b0, reset, fetch_en, upd_en, upd_taken, upd_hit;
  logic [31:0] fetch_pc, upd_pc, upd_target, target;
  logic hit, taken;
  logic [WB-1:0] hit_way, upd_way;

  btb_setassoc #(.NSETS(NSETS), .NWAYS(NWAYS), .CTR_BITS(CTR_BITS)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .hit(hit), .taken(taken), .target(target), .hit_way(hit_way),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_hit(upd_hit), .upd_way(upd_way));

  always #5 clk = ~clk;

  // Behavioural model state
  bit          mv  [NSETS][NWAYS];
  int unsigned mt  [NSETS][NWAYS];
  int unsigned mtg [NSETS][NWAYS];
  int          mc  [NSETS][NWAYS];
  int          mp  [NSETS];
  bit          e_hit, e_taken;
  int unsigned e_target;
  int          e_way;

  typedef struct { logic [31:0] pc; logic h; logic [WB-1:0] w; } pred_t;
  pred_t q[$];

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int set_of(input logic [31:0] pc);
    return int'(pc >> 2) % NSETS;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX + 2);
  endfunction

  task automatic model_lookup(input logic [31:0] pc);
    int s;
    s = set_of(pc);
    e_hit = 0; e_taken = 0; e_target = 0; e_way = 0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!e_hit && mv[s][w] && mt[s][w] == tag_of(pc)) begin
        e_hit = 1; e_way = w;
        e_taken = (mc[s][w] >= CINIT);
        e_target = mtg[s][w] << 2;
      end
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic [31:0] tg, input bit tk,
                              input bit uh, input int uw);
    int s, w;
    s = set_of(pc);
    if (uh && mv[s][uw] && mt[s][uw] == tag_of(pc)) begin
      if (tk) begin
        mc[s][uw] = (mc[s][uw] < CMAX) ? mc[s][uw] + 1 : CMAX;
        mtg[s][uw] = tg >> 2;
      end else begin
        mc[s][uw] = (mc[s][uw] > 0) ? mc[s][uw] - 1 : 0;
      end
    end else if (tk) begin
      w = -1;
      for (int i = NWAYS - 1; i >= 0; i--) if (!mv[s][i]) w = i;
      if (w < 0) begin
        w = mp[s];
        mp[s] = (mp[s] + 1) % NWAYS;
      end
      mv[s][w] = 1; mt[s][w] = tag_of(pc); mtg[s][w] = tg >> 2; mc[s][w] = CINIT;
    end
  endtask

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic step(input string tag, input bit rst, input bit fe, input logic [31:0] fpc,
                      input bit ue, input logic [31:0] upc, input logic [31:0] utg,
                      input bit utk, input bit uh, input int uw);
    reset = rst; fetch_en = fe; fetch_pc = fpc; upd_en = ue; upd_pc = upc;
    upd_target = utg; upd_taken = utk; upd_hit = uh; upd_way = WB'(uw);
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        mp[s] = 0;
        for (int w = 0; w < NWAYS; w++) mv[s][w] = 0;
      end
      e_hit = 0; e_taken = 0; e_target = 0; e_way = 0;
    end else begin
      if (fe) begin
        model_lookup(fpc);
        q.push_back('{fpc, e_hit, WB'(e_way)});
      end
      if (ue) model_update(upc, utg, utk, uh, uw);
    end
    @(posedge clk); #1;
    chk({tag, ".hit"}, {31'd0, hit}, {31'd0, e_hit});
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, e_taken});
    chk({tag, ".target"}, target, e_target);
    chk({tag, ".way"}, {{(32-WB){1'b0}}, hit_way}, 32'(e_way));
  endtask

  task automatic look(input string tag, input logic [31:0] pc);
    step(tag, 0, 1, pc, 0, 32'd0, 32'd0, 0, 0, 0);
  endtask

  task automatic upd(input string tag, input logic [31:0] pc, input logic [31:0] tg,
                     input bit tk, input bit uh, input int uw);
    step(tag, 0, 0, 32'd0, 1, pc, tg, tk, uh, uw);
  endtask

  initial begin
    logic [31:0] rpc, rtg;
    pred_t p;
    step("rst", 1, 0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0);
    step("rst", 1, 0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0);
    // Cold lookup misses
    look("cold", 32'h0000_1000);
    chk("cold_hit_const", {31'd0, hit}, 32'd0);
    // Allocate then hit with weak-taken counter
    upd("alloc", 32'h0000_1000, 32'h0000_2000, 1, 0, 0);
    look("hit1", 32'h0000_1000);
    chk("hit1_target_const", target, 32'h0000_2000);
    step("idle_hold", 0, 0, 32'h0000_5555, 0, 32'd0, 32'd0, 0, 0, 0);
    // Counter saturates low, then high
    for (int i = 0; i < 3; i++) upd("dec", 32'h0000_1000, 32'h0000_3000, 0, 1, 0);
    look("sat_lo", 32'h0000_1000);
    chk("sat_lo_taken_const", {31'd0, taken}, 32'd0);
    for (int i = 0; i < 4; i++) upd("inc", 32'h0000_1000, 32'h0000_4000, 1, 1, 0);
    look("sat_hi", 32'h0000_1000);
    upd("dec_once", 32'h0000_1000, 32'h0000_0000, 0, 1, 0);
    look("sat_hi_chk", 32'h0000_1000);
    // Round-robin eviction within set 0
    step("rst2", 1, 0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0);
    upd("a0", 32'h0000_1000, 32'h0000_A000, 1, 0, 0);
    upd("a1", 32'h0000_1040, 32'h0000_B000, 1, 0, 0);
    upd("a2", 32'h0000_1080, 32'h0000_C000, 1, 0, 0);
    look("ev0", 32'h0000_1000);
    look("ev1", 32'h0000_1040);
    look("ev2", 32'h0000_1080);
    chk("ev2_way_const", {{(32-WB){1'b0}}, hit_way}, 32'd0);
    upd("a3", 32'h0000_10C0, 32'h0000_D000, 1, 0, 0);
    look("ev3", 32'h0000_1040);
    // Stale upd_hit is treated as a miss
    upd("stale", 32'h0000_1100, 32'h0000_E000, 1, 1, 1);
    look("stale_chk", 32'h0000_1100);
    // Read-before-write on the same set
    step("rst3", 1, 0, 32'd0, 0, 32'd0, 32'd0, 0, 0, 0);
    step("rbw", 0, 1, 32'h0000_1000, 1, 32'h0000_1000, 32'h0000_2000, 1, 0, 0);
    look("rbw_next", 32'h0000_1000);
    // Reset beats simultaneous fetch and update
    upd("pre", 32'h0000_1044, 32'h0000_7000, 1, 0, 0);
    step("mid_rst", 1, 1, 32'h0000_1000, 1, 32'h0000_1008, 32'h0000_9000, 1, 0, 0);
    look("post0", 32'h0000_1000);
    look("post1", 32'h0000_1044);
    look("post2", 32'h0000_1008);
    q.delete();
    // Randomized traffic over a small pc pool to force conflicts
    for (int n = 0; n < 600; n++) begin
      rpc = ($urandom_range(0, 5) << (IDX + 2)) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rtg = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        step("r_rst", 1, $urandom_range(0, 1), rpc, 1, rpc, rtg, 1, 0, 0);
        q.delete();
      end else if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        p = q.pop_front();
        step("r_upd", 0, $urandom_range(0, 1), rpc, 1, p.pc, rtg, $urandom_range(0, 1), p.h, int'(p.w));
      end else begin
        step("r_mix", 0, $urandom_range(0, 3) != 0, rpc, $urandom_range(0, 1), rpc ^ 32'h40,
             rtg, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NWAYS - 1));
      end
      if (q.size() > 8) void'(q.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
